// File: rtl/fetch_prefetch_buffer_if.sv
// Memory fetch bus and decoder handshake bundle for the prefetch buffer.
// master = prefetch buffer; slave = instruction memory plus decoder side.
interface fetch_prefetch_buffer_if;
   logic        iMemReq;
   logic [31:0] iMemAddr;
   logic        iMemGnt;
   logic        iMemRvalid;
   logic [31:0] iMemRdata;
   logic        instValid;
   logic [31:0] instruction;
   logic [31:0] instPC;
   logic        instReady;

   modport master (
      output iMemReq, iMemAddr, instValid, instruction, instPC,
      input  iMemGnt, iMemRvalid, iMemRdata, instReady
   );

   modport slave (
      input  iMemReq, iMemAddr, instValid, instruction, instPC,
      output iMemGnt, iMemRvalid, iMemRdata, instReady
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetch, in-order FIFO, redirect.
// Ports: clk, rst (sync, active-high), redirectValid/redirectPC, fetchStall,
//   bus (master: iMem req/gnt/rvalid bus + decoder valid/ready), occupancy.
// Optional macro FETCH_BYPASS_EN: same-cycle path from iMemRdata when empty.
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirectValid,
   input  logic [31:0]            redirectPC,
   input  logic                   fetchStall,
   fetch_prefetch_buffer_if.master bus,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   hold_data;
   logic [31:0]   hold_pc;

   logic          in_fetch;
   logic [CW:0]   credit;
   logic          req;
   logic          issue;
   logic          empty;
   logic          byp;
   logic          pop_fifo;
   logic          push;
   logic [CW-1:0] drop_next;
   logic [31:0]   cur_data;
   logic [31:0]   cur_pc;

   assign in_fetch = (state == FETCH);
   assign credit   = {1'b0, count} + {1'b0, outstanding};
   // Each issued request owns a FIFO slot, so pushes never overflow.
   assign req      = in_fetch && !fetchStall && !redirectValid
                     && (credit < (CW+1)'(DEPTH));
   assign issue    = req && bus.iMemGnt;
   assign empty    = (count == '0);

`ifdef FETCH_BYPASS_EN
   assign byp = empty && in_fetch && !redirectValid && bus.iMemRvalid;
`else
   assign byp = 1'b0;
`endif

   assign pop_fifo = !empty && bus.instReady && !redirectValid;
   // A bypassed word taken by the decoder is never written.
   assign push     = bus.iMemRvalid && in_fetch && !redirectValid
                     && !(byp && bus.instReady);
   // Only one of the two terms is non-zero (outstanding in FETCH, dropCnt in DRAIN).
   assign drop_next = outstanding + drop_cnt - CW'(bus.iMemRvalid);

   always_comb begin
      cur_data = hold_data;
      cur_pc   = hold_pc;
      if (!empty) begin
         cur_data = data_mem[head];
         cur_pc   = pc_mem[head];
      end else if (byp) begin
         cur_data = bus.iMemRdata;
         cur_pc   = resp_pc;
      end
   end

   assign bus.iMemReq     = !rst && req;
   assign bus.iMemAddr    = fetch_pc;
   assign bus.instValid   = !rst && (!empty || byp);
   assign bus.instruction = rst ? 32'h0 : cur_data;
   assign bus.instPC      = rst ? 32'h0 : cur_pc;
   assign occupancy       = rst ? '0 : count;

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[tail] <= bus.iMemRdata;
         pc_mem[tail]   <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         head        <= '0;
         tail        <= '0;
         hold_data   <= 32'h0;
         hold_pc     <= 32'h0;
      end else begin
         // Keeps the last shown word on the outputs once the FIFO drains.
         hold_data <= cur_data;
         hold_pc   <= cur_pc;
         if (redirectValid) begin
            fetch_pc    <= {redirectPC[31:2], 2'b00};
            resp_pc     <= {redirectPC[31:2], 2'b00};
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_next;
            state       <= (drop_next != '0) ? DRAIN : FETCH;
         end else begin
            if (issue)
               fetch_pc <= fetch_pc + 32'd4;
            unique case (state)
               FETCH: begin
                  outstanding <= outstanding + CW'(issue)
                                 - CW'(bus.iMemRvalid);
                  if (bus.iMemRvalid)
                     resp_pc <= resp_pc + 32'd4;
               end
               DRAIN: begin
                  if (bus.iMemRvalid)
                     drop_cnt <= drop_cnt - 1'b1;
                  if (drop_next == '0)
                     state <= FETCH;
               end
               default: state <= FETCH;
            endcase
            if (push)
               tail <= tail + 1'b1;
            if (pop_fifo)
               head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop_fifo);
         end
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer.
// Memory model with random grant/latency plus a stream-level reference model.
module tb_fetch_prefetch_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        fetchStall;
   logic [2:0]  occupancy;

   fetch_prefetch_buffer_if bus_if ();

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .redirectValid (redirectValid),
      .redirectPC    (redirectPC),
      .fetchStall    (fetchStall),
      .bus           (bus_if),
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int gnt_pct = 100;
   int lat_min = 1;
   int lat_max = 1;
   bit hold    = 1'b0;

   bit          t_rst;
   bit          t_redir;
   bit          t_stall;
   bit          t_ready;
   logic [31:0] t_rpc;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   rsp_t        mq[$];
   logic [31:0] issue_log[$];
   int          cyc = 0;
   int          n_issue = 0;
   int          n_pop = 0;
   logic [31:0] exp_issue;
   logic [31:0] exp_pop;

   typedef struct {
      logic [31:0] rpc;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] a2;
   } vec_t;

   vec_t vecs[4];

   function automatic logic [31:0] memfun(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe
   // what the DUT will act on at the next rising edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      rst                = t_rst;
      redirectValid      = t_redir;
      redirectPC         = t_rpc;
      fetchStall         = t_stall;
      bus_if.instReady   = t_ready;
      bus_if.iMemGnt     = ($urandom_range(99) < gnt_pct);
      bus_if.iMemRvalid  = 1'b0;
      bus_if.iMemRdata   = 32'hDEAD_BEEF;
      if (t_rst)
         mq.delete();
      else if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
         bus_if.iMemRvalid = 1'b1;
         bus_if.iMemRdata  = memfun(mq[0].addr);
         void'(mq.pop_front());
      end
      #1;
      if (t_rst) begin
         exp_issue = 32'h0;
         exp_pop   = 32'h0;
         return;
      end
      if (redirectValid)
         check("req_in_redirect", bus_if.iMemReq, 0);
      if (bus_if.iMemReq && bus_if.iMemGnt) begin
         check("issue_addr", bus_if.iMemAddr, exp_issue);
         issue_log.push_back(bus_if.iMemAddr);
         mq.push_back('{bus_if.iMemAddr,
                        cyc + $urandom_range(lat_max, lat_min)});
         exp_issue = exp_issue + 32'd4;
         n_issue++;
      end
      if (bus_if.instValid && bus_if.instReady && !redirectValid) begin
         check("pop_pc", bus_if.instPC, exp_pop);
         check("pop_data", bus_if.instruction, memfun(exp_pop));
         exp_pop = exp_pop + 32'd4;
         n_pop++;
      end
      if (redirectValid) begin
         exp_issue = t_rpc & 32'hFFFF_FFFC;
         exp_pop   = t_rpc & 32'hFFFF_FFFC;
      end
      check("occ_bound", 32'(occupancy <= DEPTH), 1);
`ifndef FETCH_BYPASS_EN
      check("valid_vs_occ", 32'(bus_if.instValid),
            32'(occupancy != 0));
`endif
   endtask

   task automatic do_reset();
      t_rst   = 1'b1;
      t_redir = 1'b0;
      t_stall = 1'b0;
      hold    = 1'b0;
      step();
      step();
      t_rst = 1'b0;
      issue_log.delete();
   endtask

   initial begin
      int base;
      int k;
      rst               = 1'b1;
      redirectValid     = 1'b0;
      redirectPC        = 32'h0;
      fetchStall        = 1'b0;
      bus_if.iMemGnt    = 1'b0;
      bus_if.iMemRvalid = 1'b0;
      bus_if.iMemRdata  = 32'h0;
      bus_if.instReady  = 1'b0;
      t_rpc             = 32'h0;
      t_ready           = 1'b1;

      vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
      vecs[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

      // Reset outputs
      do_reset();
      t_rst = 1'b1;
      step();
      check("rst_req", bus_if.iMemReq, 0);
      check("rst_valid", bus_if.instValid, 0);
      check("rst_inst", bus_if.instruction, 0);
      check("rst_pc", bus_if.instPC, 0);
      check("rst_occ", occupancy, 0);
      t_rst = 1'b0;

      // Streaming: one instruction per cycle in steady state
      t_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      base = n_pop;
      for (int i = 0; i < 10; i++) step();
      check("stream_rate", n_pop - base, 10);

      // Fill with decoder stalled
      do_reset();
      t_ready = 1'b0;
      base = n_issue;
      for (int i = 0; i < 12; i++) step();
      check("fill_issues", n_issue - base, 4);
      check("fill_occ", occupancy, 4);
      check("fill_req", bus_if.iMemReq, 0);
      t_ready = 1'b1;
      step();
      t_ready = 1'b0;
      base = n_issue;
      step();
      check("pop1_occ", occupancy, 3);
      check("pop1_req", bus_if.iMemReq, 1);
      for (int i = 0; i < 5; i++) step();
      check("pop1_issues", n_issue - base, 1);
      check("pop1_refill", occupancy, 4);

      // Redirect with three outstanding
      do_reset();
      t_ready = 1'b1;
      hold    = 1'b1;
      for (int i = 0; i < 3; i++) step();
      t_redir = 1'b1;
      t_rpc   = 32'h0000_0102;
      step();
      check("rd3_req", bus_if.iMemReq, 0);
      t_redir = 1'b0;
      step();
      check("rd3_occ", occupancy, 0);
      check("rd3_valid", bus_if.instValid, 0);
      check("rd3_drain_req", bus_if.iMemReq, 0);
      hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rd3_drop_rv", bus_if.iMemRvalid, 1);
         check("rd3_drop_req", bus_if.iMemReq, 0);
      end
      step();
      check("rd3_resume_req", bus_if.iMemReq, 1);
      check("rd3_resume_addr", bus_if.iMemAddr, 32'h0000_0100);
      base = n_pop;
      for (int i = 0; i < 10; i++) step();
      check("rd3_pops", 32'(n_pop > base), 1);

      // Redirect coincident with a response, occupancy 2
      do_reset();
      t_ready = 1'b0;
      hold    = 1'b1;
      for (int i = 0; i < 4; i++) step();
      hold = 1'b0;
      step();
      step();
      t_redir = 1'b1;
      t_rpc   = 32'h0000_2000;
      t_ready = 1'b1;
      step();
      check("rdc_occ_before", occupancy, 2);
      check("rdc_rvalid", bus_if.iMemRvalid, 1);
      t_redir = 1'b0;
      hold    = 1'b1;
      step();
      check("rdc_occ_after", occupancy, 0);
      check("rdc_valid", bus_if.instValid, 0);
      check("rdc_drain", bus_if.iMemReq, 0);
      hold = 1'b0;
      step();
      check("rdc_last_drop", bus_if.iMemReq, 0);
      step();
      check("rdc_resume_req", bus_if.iMemReq, 1);
      check("rdc_resume_addr", bus_if.iMemAddr, 32'h0000_2000);

      // fetchStall with two outstanding
      do_reset();
      t_ready = 1'b0;
      hold    = 1'b1;
      step();
      step();
      t_stall = 1'b1;
      step();
      check("stall_req", bus_if.iMemReq, 0);
      hold = 1'b0;
      step();
      check("stall_req_r1", bus_if.iMemReq, 0);
      step();
      check("stall_req_r2", bus_if.iMemReq, 0);
      step();
      check("stall_occ", occupancy, 2);
      check("stall_valid", bus_if.instValid, 1);
      t_stall = 1'b0;

      // First-word latency / bypass
      do_reset();
      t_ready = 1'b1;
      hold    = 1'b1;
      step();
      t_stall = 1'b1;
      step();
      hold = 1'b0;
      step();
`ifdef FETCH_BYPASS_EN
      check("byp_valid", bus_if.instValid, 1);
      check("byp_pc", bus_if.instPC, 32'h0);
      check("byp_data", bus_if.instruction, memfun(32'h0));
      check("byp_occ", occupancy, 0);
      step();
      check("byp_occ_next", occupancy, 0);
      check("byp_valid_next", bus_if.instValid, 0);
`else
      check("lat_valid0", bus_if.instValid, 0);
      step();
      check("lat_valid1", bus_if.instValid, 1);
      check("lat_pc", bus_if.instPC, 32'h0);
      check("lat_data", bus_if.instruction, memfun(32'h0));
      check("lat_occ", occupancy, 1);
`endif
      t_stall = 1'b0;

      // Table: redirect targets and the next three fetch addresses
      do_reset();
      t_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      for (int v = 0; v < 4; v++) begin
         t_redir = 1'b1;
         t_rpc   = vecs[v].rpc;
         step();
         t_redir = 1'b0;
         issue_log.delete();
         k = 0;
         while (issue_log.size() < 3 && k < 40) begin
            step();
            k++;
         end
         if (issue_log.size() < 3) begin
            check("tbl_timeout", 32'(issue_log.size()), 3);
         end else begin
            check("tbl_a0", issue_log[0], vecs[v].a0);
            check("tbl_a1", issue_log[1], vecs[v].a1);
            check("tbl_a2", issue_log[2], vecs[v].a2);
         end
         for (int i = 0; i < 4; i++) step();
      end

      // Random traffic against the stream model
      gnt_pct = 70;
      lat_min = 1;
      lat_max = 4;
      base = n_pop;
      for (int i = 0; i < 3000; i++) begin
         t_ready = ($urandom_range(99) < 70);
         t_stall = ($urandom_range(99) < 10);
         t_redir = ($urandom_range(99) < 3);
         if ($urandom_range(3) == 0)
            t_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         else
            t_rpc = $urandom;
         step();
      end
      t_redir = 1'b0;
      t_stall = 1'b0;
      t_ready = 1'b1;
      for (int i = 0; i < 30; i++) step();
      check("rand_progress", 32'(n_pop - base > 200), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
